// File: rtl/keypad_buffer_pkg.sv
// -----------------------------------------------------------------------------
// keypad_buffer_pkg
// Shared peripheral definitions for the keypad buffer:
//   - CPU register addresses (DATA / STATUS)
//   - STATUS word bit positions
//   - capture FSM state encoding
//   - helper that assembles the STATUS word
// -----------------------------------------------------------------------------
package keypad_buffer_pkg;

    // Register select values seen on the 1-bit addr port
    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    // STATUS word layout
    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_MSB = 12;
    localparam int STAT_COUNT_W   = STAT_COUNT_MSB - STAT_COUNT_LSB + 1;

    // Key capture states
    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_HELD    = 2'd1,
        CAP_RELEASE = 2'd2
    } cap_state_t;

    // Builds the STATUS word; every bit not named here reads as zero.
    function automatic logic [31:0] pack_status(
        input logic                    not_empty,
        input logic                    full,
        input logic                    overflow,
        input logic [STAT_COUNT_W-1:0] count
    );
        logic [31:0] word;
        word                                = '0;
        word[STAT_NOT_EMPTY]                = not_empty;
        word[STAT_FULL]                     = full;
        word[STAT_OVERFLOW]                 = overflow;
        word[STAT_COUNT_MSB:STAT_COUNT_LSB] = count;
        return word;
    endfunction

endpackage

// File: rtl/keypad_buffer_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock circular FIFO with show-ahead output (dout is the current head).
//
// Ports:
//   clk    in   clock, all updates on rising edge
//   rst    in   asynchronous active-high reset (pointers and count only)
//   push   in   write din this cycle
//   pop    in   drop the head entry this cycle
//   din    in   WIDTH-bit write data
//   dout   out  WIDTH-bit head entry (meaningless while empty)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  number of stored entries, 0..DEPTH
//
// A pop on an empty FIFO is ignored. A push while full is accepted only when
// a pop happens in the same cycle; otherwise it is dropped and the caller is
// expected to flag the overflow.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage carries no reset: an entry is only ever read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_buffer.sv
// -----------------------------------------------------------------------------
// keypad_buffer
// Captures one FIFO entry per keypress from a keypad scanner and exposes the
// FIFO to a CPU through a two-register read-only bus interface.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   key_code  in   8-bit ASCII code from the scanner, 0 = no key
//   rd        in   one-cycle read strobe
//   addr      in   0 = DATA (pops the FIFO), 1 = STATUS
//   rd_data   out  32-bit registered read result, held until the next rd
//   irq       out  registered "FIFO non-empty"
//
// A key is pushed once when first seen, then ignored until the code has been
// zero long enough to count as released; a non-zero code during the release
// window is treated as contact bounce and returns to the held state.
// -----------------------------------------------------------------------------
module keypad_buffer
    import keypad_buffer_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  key_code,
    input  logic        rd,
    input  logic        addr,
    output logic [31:0] rd_data,
    output logic        irq
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

    logic [7:0]       code_q;
    cap_state_t       state;
    cap_state_t       state_next;
    logic [REL_W-1:0] rel_cnt;
    logic [REL_W-1:0] rel_cnt_next;
    logic             push;
    logic             data_rd;
    logic             status_rd;
    logic             overflow;
    logic             overflow_event;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign data_rd   = rd && (addr == ADDR_DATA);
    assign status_rd = rd && (addr == ADDR_STATUS);

    // A push is only lost when the FIFO is full and nothing leaves this cycle.
    assign overflow_event = push && fifo_full && !data_rd;

    // Register the scanner code once; every capture decision looks at code_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q <= '0;
        end else begin
            code_q <= key_code;
        end
    end

    // Capture FSM state and release counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CAP_IDLE;
            rel_cnt <= '0;
        end else begin
            state   <= state_next;
            rel_cnt <= rel_cnt_next;
        end
    end

    // Capture FSM next state. The push is issued on the IDLE->HELD transition
    // only, so a code change while held never produces a second entry.
    always_comb begin
        state_next   = state;
        rel_cnt_next = rel_cnt;
        push         = 1'b0;
        case (state)
            CAP_IDLE: begin
                if (code_q != 8'd0) begin
                    push       = 1'b1;
                    state_next = CAP_HELD;
                end
            end
            CAP_HELD: begin
                if (code_q == 8'd0) begin
                    state_next   = CAP_RELEASE;
                    rel_cnt_next = '0;
                end
            end
            CAP_RELEASE: begin
                if (code_q != 8'd0) begin
                    state_next = CAP_HELD;
                end else if (rel_cnt == REL_LAST) begin
                    state_next   = CAP_IDLE;
                    rel_cnt_next = '0;
                end else begin
                    rel_cnt_next = rel_cnt + REL_W'(1);
                end
            end
            default: begin
                state_next   = CAP_IDLE;
                rel_cnt_next = '0;
            end
        endcase
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (data_rd),
        .din   (code_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky overflow flag. A STATUS read clears it from the next cycle on,
    // but a simultaneous overflow keeps it set so the event is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (overflow_event) begin
            overflow <= 1'b1;
        end else if (status_rd) begin
            overflow <= 1'b0;
        end
    end

    // Read data register: loaded only on a strobe and held otherwise.
    // STATUS reports the state as it was before this cycle's push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (data_rd) begin
            rd_data <= fifo_empty ? 32'd0 : {24'd0, fifo_dout};
        end else if (status_rd) begin
            rd_data <= pack_status(!fifo_empty, fifo_full, overflow,
                                   STAT_COUNT_W'(fifo_count));
        end
    end

    // Interrupt follows the FIFO count one cycle behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (fifo_count != '0);
        end
    end

endmodule
